// File: rtl/lifo_stack_pkg.sv
// Shared definitions for the LIFO stack: the per-edge operation encoding
// and the pure decode that turns raw requests plus status into one operation.
package lifo_stack_pkg;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_REPLACE,
      OP_CLEAR,
      OP_OVF,
      OP_UNF
   } lifo_op_e;

   // Priority: clear, then push+pop (replace, or plain push on empty),
   // then lone push, then lone pop.
   function automatic lifo_op_e lifo_decode(input logic push,
                                            input logic pop,
                                            input logic clear,
                                            input logic empty,
                                            input logic full);
      lifo_op_e op;
      op = OP_NONE;
      if (clear) begin
         op = OP_CLEAR;
      end else if (push && pop) begin
         op = empty ? OP_PUSH : OP_REPLACE;
      end else if (push) begin
         op = full ? OP_OVF : OP_PUSH;
      end else if (pop) begin
         op = empty ? OP_UNF : OP_POP;
      end
      return op;
   endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// Storage array for the LIFO stack: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset; validity is
// tracked by the occupancy count in the top level.
module lifo_stack_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 32,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Write the addressed entry on the rising edge when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised synchronous LIFO stack with occupancy count, status flags,
// replace-top on simultaneous push+pop, synchronous clear and registered
// overflow/underflow pulses.
module lifo_stack
   import lifo_stack_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 32,
   parameter int AFULL_LVL = DEPTH - 2,
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic              clear,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              overflow,
   output logic              underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   lifo_op_e          op;
   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [AW-1:0]     top_addr;
   logic [DATA_W-1:0] mem_rdata;

   // Status is decoded from the registered count only.
   assign empty       = (count_q == '0);
   assign full        = (count_q == CNT_W'(DEPTH));
   assign almost_full = (count_q >= CNT_W'(AFULL_LVL));
   assign count       = count_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

   assign op = lifo_decode(push, pop, clear, empty, full);

   // Top entry sits at count-1; on empty this wraps but d_out masks it.
   assign top_addr  = AW'(count_q) - AW'(1);
   assign mem_waddr = (op == OP_REPLACE) ? top_addr : AW'(count_q);

   // Next count, memory write enable and error pulses from the decoded op.
   always_comb begin
      count_d     = count_q;
      mem_we      = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      case (op)
         OP_CLEAR:   count_d = '0;
         OP_PUSH: begin
            mem_we  = 1'b1;
            count_d = count_q + CNT_W'(1);
         end
         OP_REPLACE: mem_we = 1'b1;
         OP_POP:     count_d = count_q - CNT_W'(1);
         OP_OVF:     overflow_d = 1'b1;
         OP_UNF:     underflow_d = 1'b1;
         default:    ;
      endcase
   end

   // Occupancy and error-pulse registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   lifo_stack_mem #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk  (clk),
      .we   (mem_we),
      .waddr(mem_waddr),
      .wdata(d_in),
      .raddr(top_addr),
      .rdata(mem_rdata)
   );

   assign d_out = empty ? '0 : mem_rdata;

endmodule

// File: tb/tb_lifo_stack.sv
// Bench for lifo_stack: a queue-based stack model predicts count, top and
// flags after every edge; directed scenarios plus a randomized burst.
module tb_lifo_stack;

   localparam int DATA_W    = 8;
   localparam int DEPTH     = 32;
   localparam int AFULL_LVL = DEPTH - 2;
   localparam int CNT_W     = $clog2(DEPTH + 1);
   localparam int VEC_W     = CNT_W + DATA_W + 5;

   logic              clk;
   logic              rst_n;
   logic              push;
   logic              pop;
   logic              clear;
   logic [DATA_W-1:0] d_in;
   logic [DATA_W-1:0] d_out;
   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              full;
   logic              almost_full;
   logic              overflow;
   logic              underflow;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DATA_W-1:0] mdl_q[$];
   logic              mdl_ovf;
   logic              mdl_unf;

   lifo_stack #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .AFULL_LVL(AFULL_LVL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .pop        (pop),
      .clear      (clear),
      .d_in       (d_in),
      .d_out      (d_out),
      .count      (count),
      .empty      (empty),
      .full       (full),
      .almost_full(almost_full),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Observed status bundle: {count, d_out, empty, full, almost_full, overflow, underflow}
   function automatic logic [VEC_W-1:0] obs_vec();
      return {count, d_out, empty, full, almost_full, overflow, underflow};
   endfunction

   // Expected status bundle derived from the model stack contents
   function automatic logic [VEC_W-1:0] exp_vec();
      int n;
      logic [DATA_W-1:0] top;
      n   = mdl_q.size();
      top = (n == 0) ? '0 : mdl_q[n-1];
      return {CNT_W'(n), top, (n == 0), (n == DEPTH), (n >= AFULL_LVL), mdl_ovf, mdl_unf};
   endfunction

   // Stack semantics applied to the model for one edge
   task automatic model_apply(input logic p, input logic q, input logic c,
                              input logic [DATA_W-1:0] d);
      mdl_ovf = 1'b0;
      mdl_unf = 1'b0;
      if (c) begin
         mdl_q.delete();
      end else if (p && q) begin
         if (mdl_q.size() == 0) mdl_q.push_back(d);
         else mdl_q[mdl_q.size()-1] = d;
      end else if (p) begin
         if (mdl_q.size() == DEPTH) mdl_ovf = 1'b1;
         else mdl_q.push_back(d);
      end else if (q) begin
         if (mdl_q.size() == 0) mdl_unf = 1'b1;
         else void'(mdl_q.pop_back());
      end
   endtask

   // Drive one request at the falling edge, let the rising edge take it,
   // update the model, and return 1 time unit after the edge.
   task automatic drive(input logic p, input logic q, input logic c,
                        input logic [DATA_W-1:0] d);
      @(negedge clk);
      push  = p;
      pop   = q;
      clear = c;
      d_in  = d;
      @(posedge clk);
      model_apply(p, q, c, d);
      #1;
      push  = 1'b0;
      pop   = 1'b0;
      clear = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      mdl_q.delete();
      mdl_ovf = 1'b0;
      mdl_unf = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      push = 1'b0; pop = 1'b0; clear = 1'b0; d_in = '0;
      rst_n = 1'b0;
      mdl_q.delete();
      mdl_ovf = 1'b0;
      mdl_unf = 1'b0;
      #12;
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL reset_hold: got %h expected %h", obs_vec(), exp_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 8'hFF);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, DATA_W'(8'h40 + i));
      checks++;
      if (count !== CNT_W'(5) || d_out !== 8'h44) begin
         errors++;
         $display("FAIL midrst_pre: count=%0d d_out=%h expected 5/44", count, d_out);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (count !== '0 || d_out !== '0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async: count=%0d d_out=%h empty=%b expected 0/00/1", count, d_out, empty);
      end
      mdl_q.delete();
      mdl_ovf = 1'b0;
      mdl_unf = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 8'h9C);
      checks++;
      if (obs_vec() !== exp_vec() || d_out !== 8'h9C) begin
         errors++;
         $display("FAIL midrst_first_push: got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_push_pop();
      logic [DATA_W-1:0] exp_top [6];
      logic [DATA_W-1:0] vals [3];
      do_reset();
      exp_top = '{8'h11, 8'h22, 8'h33, 8'h22, 8'h11, 8'h00};
      vals    = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 6; i++) begin
         if (i < 3) drive(1'b1, 1'b0, 1'b0, vals[i]);
         else drive(1'b0, 1'b1, 1'b0, 8'hEE);
         checks++;
         if (d_out !== exp_top[i] || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL push_pop[%0d]: d_out=%h want %h status %h want %h",
                     i, d_out, exp_top[i], obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1'b0, 1'b0, DATA_W'(i + 1));
         checks++;
         if (obs_vec() !== exp_vec() || almost_full !== (i + 1 >= AFULL_LVL)) begin
            errors++;
            $display("FAIL fill[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      drive(1'b1, 1'b0, 1'b0, 8'hAA);
      checks++;
      if (overflow !== 1'b1 || full !== 1'b1 || d_out !== 8'h20 || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL overflow_pulse: ovf=%b full=%b d_out=%h expected 1/1/20", overflow, full, d_out);
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (overflow !== 1'b0 || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL overflow_end: ovf=%b expected 0", overflow);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (underflow !== 1'b1 || count !== '0 || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL underflow_single: unf=%b count=%0d expected 1/0", underflow, count);
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (underflow !== 1'b0) begin
         errors++;
         $display("FAIL underflow_end: unf=%b expected 0", underflow);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00);
         checks++;
         if (underflow !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL underflow_b2b[%0d]: unf=%b expected 1", i, underflow);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (underflow !== 1'b0) begin
         errors++;
         $display("FAIL underflow_b2b_end: unf=%b expected 0", underflow);
      end
   endtask

   task automatic test_replace();
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 8'h11);
      drive(1'b1, 1'b0, 1'b0, 8'h22);
      drive(1'b1, 1'b0, 1'b0, 8'h33);
      drive(1'b1, 1'b1, 1'b0, 8'h55);
      checks++;
      if (d_out !== 8'h55 || count !== CNT_W'(3) || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL replace_top: d_out=%h count=%0d expected 55/3", d_out, count);
      end
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (d_out !== 8'h22) begin
         errors++;
         $display("FAIL replace_below: d_out=%h expected 22", d_out);
      end
      while (mdl_q.size() < DEPTH) drive(1'b1, 1'b0, 1'b0, 8'h5A);
      drive(1'b1, 1'b1, 1'b0, 8'hC3);
      checks++;
      if (overflow !== 1'b0 || full !== 1'b1 || d_out !== 8'hC3 || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL replace_full: ovf=%b full=%b d_out=%h expected 0/1/c3", overflow, full, d_out);
      end
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 8'h77);
      checks++;
      if (count !== CNT_W'(1) || d_out !== 8'h77 || underflow !== 1'b0 || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL replace_empty: count=%0d d_out=%h unf=%b expected 1/77/0", count, d_out, underflow);
      end
   endtask

   task automatic test_clear();
      do_reset();
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, DATA_W'($urandom_range(1, 255)));
      drive(1'b1, 1'b1, 1'b1, 8'hAB);
      checks++;
      if (count !== '0 || empty !== 1'b1 || d_out !== '0 || overflow !== 1'b0 ||
          underflow !== 1'b0 || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL clear_priority: got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      int r;
      logic p, q, c;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         c = (r < 3);
         p = ($urandom_range(0, 99) < 58);
         q = ($urandom_range(0, 99) < 45);
         drive(p, q, c, DATA_W'($urandom));
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random[%0d] p=%b q=%b c=%b: got %h expected %h",
                     i, p, q, c, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_burst();
      test_push_pop();
      test_fill_overflow();
      test_underflow();
      test_replace();
      test_clear();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
